// File: rtl/mmio_timer_bank_if.sv
// mmio_timer_bank_if: data-memory bus view seen by the timer bank.
// Master drives address/strobe/data, slave returns combinational rdata.
interface mmio_timer_bank_if;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output we, addr, wdata,
    input  rdata
  );

  modport slave (
    input  we, addr, wdata,
    output rdata
  );
endinterface

// File: rtl/mmio_timer_bank.sv
// mmio_timer_bank: CHANNELS memory-mapped down-counters, shared prescaler,
// W1C pending register and per-channel / aggregate interrupt outputs.
module mmio_timer_bank #(
  parameter int          CHANNELS  = 4,
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h4000_1000
) (
  input  logic                clk,
  input  logic                rst,
  mmio_timer_bank_if.slave    bus,
  output logic [CHANNELS-1:0] irq,
  output logic                irq_any
);

  logic                hit;
  logic [3:0]          ch_sel;
  logic [1:0]          ch_reg;
  logic [5:0]          g_sel;
  logic                ch_hit;
  logic                pend_hit;
  logic                pre_hit;
  logic                wr;
  logic                wr_pend;
  logic                wr_pre;
  logic [CHANNELS-1:0] wr_ctrl;
  logic [CHANNELS-1:0] wr_load;
  logic [CHANNELS-1:0] wr_count;

  logic [CHANNELS-1:0] en;
  logic [CHANNELS-1:0] ar;
  logic [CHANNELS-1:0] ie;
  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] expire;
  logic [WIDTH-1:0]    load  [CHANNELS];
  logic [WIDTH-1:0]    count [CHANNELS];

  logic [15:0]         prescale;
  logic [15:0]         pc;
  logic                tick;

  logic [31:0]         ch_data;
  logic [31:0]         rdata_c;
  logic                unused_bits;

  assign hit      = bus.addr[31:9] == BASE_ADDR[31:9];
  assign ch_sel   = bus.addr[7:4];
  assign ch_reg   = bus.addr[3:2];
  assign g_sel    = bus.addr[7:2];
  assign ch_hit   = hit & ~bus.addr[8];
  assign pend_hit = hit & bus.addr[8] & (g_sel == 6'd0);
  assign pre_hit  = hit & bus.addr[8] & (g_sel == 6'd1);
  assign wr       = bus.we & ch_hit;
  assign wr_pend  = bus.we & pend_hit;
  assign wr_pre   = bus.we & pre_hit;
  assign tick     = pc == prescale;

  assign irq         = pend & ie;
  assign irq_any     = |irq;
  assign bus.rdata   = rdata_c;
  assign unused_bits = ^{bus.addr[1:0], bus.wdata};

  // Per-channel write strobes and expiry detection.
  always_comb begin
    wr_ctrl  = '0;
    wr_load  = '0;
    wr_count = '0;
    expire   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_ctrl[i]  = wr & (ch_sel == 4'(i)) & (ch_reg == 2'd0);
      wr_load[i]  = wr & (ch_sel == 4'(i)) & (ch_reg == 2'd1);
      wr_count[i] = wr & (ch_sel == 4'(i)) & (ch_reg == 2'd2);
      expire[i]   = tick & en[i] & (count[i] == '0);
    end
  end

  // Read mux; unmapped channels, reserved words and misses read zero.
  always_comb begin
    ch_data = '0;
    rdata_c = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_sel == 4'(i)) begin
        case (ch_reg)
          2'd0:    ch_data = {29'd0, ie[i], ar[i], en[i]};
          2'd1:    ch_data = 32'(load[i]);
          2'd2:    ch_data = 32'(count[i]);
          default: ch_data = '0;
        endcase
      end
    end
    unique case (1'b1)
      ch_hit:   rdata_c = ch_data;
      pend_hit: rdata_c = 32'(pend);
      pre_hit:  rdata_c = {16'd0, prescale};
      default:  rdata_c = '0;
    endcase
  end

  // Shared prescaler; a PRESCALE write restarts the phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale <= '0;
      pc       <= '0;
    end else if (wr_pre) begin
      prescale <= bus.wdata[15:0];
      pc       <= '0;
    end else if (tick) begin
      pc <= '0;
    end else begin
      pc <= pc + 16'd1;
    end
  end

  // Channel counters; software writes are ordered last so they win.
  always_ff @(posedge clk) begin
    if (rst) begin
      en <= '0;
      ar <= '0;
      ie <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        load[i]  <= '0;
        count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (tick && en[i]) begin
          if (count[i] != '0)
            count[i] <= count[i] - WIDTH'(1);
          else if (ar[i])
            count[i] <= load[i];
          else
            en[i] <= 1'b0;
        end
        if (wr_ctrl[i]) begin
          en[i] <= bus.wdata[0];
          ar[i] <= bus.wdata[1];
          ie[i] <= bus.wdata[2];
        end
        if (wr_load[i])
          load[i] <= bus.wdata[WIDTH-1:0];
        if (wr_count[i])
          count[i] <= bus.wdata[WIDTH-1:0];
      end
    end
  end

  // Pending bits: W1C clear, a same-cycle expiry keeps the bit set.
  always_ff @(posedge clk) begin
    if (rst)
      pend <= '0;
    else
      pend <= (pend & ~(wr_pend ? bus.wdata[CHANNELS-1:0] : '0))
            | expire;
  end

endmodule

// File: doc/mmio_timer_bank.md
# mmio_timer_bank

Parametrised multi-channel memory-mapped timer and interrupt source for the MIPS SOPC, replacing the single fixed timer inside the peripheral block. It provides CHANNELS independent down-counters with one-shot or periodic modes, a shared prescaler, per-channel interrupt enables and a write-1-to-clear pending register. It sits on the same data-memory address/write-enable/data bus as data_ram and peripheral. Its per-channel and aggregate interrupt outputs feed the core's `int_i` vector.

## Interface

Parameters:
- CHANNELS, 4, number of timer channels (1..8)
- WIDTH, 32, counter/load width in bits (8..32)
- BASE_ADDR, 32'h4000_1000, byte base address; must be 512-byte aligned

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- we  in  1  write strobe, qualified by address match
- addr  in  32  byte address from MEM stage
- wdata  in  32  write data
- rdata  out  32  read data (combinational from addr)
- irq  out  CHANNELS  per-channel interrupt, `pending[i] & IE[i]`
- irq_any  out  1  OR of irq

## Operation

- Decode: hit when `addr[31:9] == BASE_ADDR[31:9]`; `addr[1:0]` ignored. Misses: writes ignored, rdata = 0.
- Channel registers at `BASE + 16*i`, with i = addr[7:4]. Indices ≥ CHANNELS are unmapped: read 0, writes ignored.
  - +0x0 CTRL: bit0 EN, bit1 AR (auto-reload), bit2 IE; other bits read 0.
  - +0x4 LOAD: WIDTH bits.
  - +0x8 COUNT: WIDTH bits; a write loads the counter directly.
  - +0xC: reserved, reads 0.
- Global registers:
  - BASE+0x100 PENDING: bit i set by channel i expiry. Writing 1 to a bit clears it; writing 0 has no effect.
  - BASE+0x104 PRESCALE: 16 bits.
- WIDTH handling: values narrower than 32 bits are zero-extended on read; writes are truncated to WIDTH.
- Prescaler: a free-running counter pc generates `tick` when pc == PRESCALE, then pc returns to 0. PRESCALE = 0 gives a tick every cycle. Any write to PRESCALE resets pc to 0.
- Per-channel behaviour on a tick with EN = 1:
  - COUNT != 0: COUNT decrements by 1.
  - COUNT == 0: PENDING[i] is set. If AR = 1, COUNT <= LOAD. If AR = 0, EN clears (one-shot) and COUNT holds at 0.
  - Resulting period in auto-reload mode: LOAD+1 ticks.
- Channels with EN = 0 hold COUNT.
- Simultaneous events:
  - A software write to CTRL or COUNT in the same cycle as a hardware update of that field: the software write wins.
  - A W1C clear in the same cycle as a hardware set of the same PENDING bit: the set wins, and the bit stays 1.
  - A write to LOAD during reload: COUNT takes the old LOAD; the new LOAD applies from the next reload.

## Timing

- Reset values (all outputs and registers): CTRL = 0, LOAD = 0, COUNT = 0, PENDING = 0, PRESCALE = 0, pc = 0, irq = 0, irq_any = 0.
- Reset is synchronous and overrides any concurrent write or tick. Reset mid-count returns all state to reset values at that edge.
- Writes take effect at the clk edge on which `we` is sampled high.
- rdata is combinational and reflects register state after the most recent edge. There is no read side effect.
- EN written at edge N: the first tick can be consumed at edge N+1.
- irq and irq_any are combinational from registered PENDING/IE. They assert in the cycle after the expiry edge, with no further latency.

## Test plan

- Periodic expiry:
  - Stimulus: PRESCALE = 0; ch0 LOAD = 3, COUNT = 3; then CTRL = 0x7 at edge N.
  - Response: COUNT reads 2, 1, 0 after edges N+1..N+3. PENDING[0] = 1, irq[0] = 1, COUNT = 3 after edge N+4. PENDING[0] sets again after edge N+8.
- One-shot:
  - Stimulus: ch1 COUNT = 2, CTRL = 0x5.
  - Response: after 3 ticks, PENDING[1] = 1, CTRL reads 0x4, COUNT stays 0 indefinitely.
- Prescaler:
  - Stimulus: PRESCALE = 4, ch0 COUNT = 1, AR = 1, LOAD = 1.
  - Response: COUNT changes only every 5th cycle. PENDING sets 10 cycles after enable.
- W1C and collision:
  - Stimulus: write PENDING = 0x1 while PENDING[0] = 1 → bit clears, irq_any drops next cycle. Then repeat the clear write on the exact expiry edge.
  - Response: on the collision, PENDING[0] stays 1.
- Masking and decode:
  - Stimulus: IE = 0 with a channel expiring → PENDING set, irq = 0. Write to channel index CHANNELS, and read BASE+0x10C.
  - Response: no state change; the read returns 0. A WIDTH = 8 build reading COUNT after writing 0x1FF returns 0xFF.
- Reset mid-operation:
  - Stimulus: assert rst while two channels are running with PENDING = 0x3.
  - Response: next cycle all registers and outputs are 0, and no expiry occurs afterward until software reprograms the block.
